// File: rtl/program_counter_stack.sv
// Program counter with W-bus drive/load and a CALL/RET return-address stack.
// Optional macro PC_WRAP_FLAG_EN adds the registered pc_wrap pulse output.
module program_counter_stack #(
  parameter int ADDR_WIDTH  = 4,
  parameter int STACK_DEPTH = 4,
  parameter int SP_WIDTH    = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cp,
  input  logic                  enable,
  input  logic                  load,
  input  logic                  call,
  input  logic                  ret,
  inout  wire  [ADDR_WIDTH-1:0] w_bus,
  output logic [ADDR_WIDTH-1:0] pc_out,
  output logic [SP_WIDTH-1:0]   stack_level,
  output logic                  stack_full,
  output logic                  stack_empty,
  output logic                  stack_ovf,
  output logic                  stack_unf
`ifdef PC_WRAP_FLAG_EN
  ,
  output logic                  pc_wrap
`endif
);

  typedef enum logic [2:0] {
    OP_HOLD,
    OP_COUNT,
    OP_LOAD,
    OP_CALL,
    OP_CALL_REJECT,
    OP_RET,
    OP_RET_REJECT
  } op_e;

  localparam logic [SP_WIDTH-1:0]   SP_ONE    = SP_WIDTH'(1);
  localparam logic [SP_WIDTH-1:0]   SP_DEPTH  = SP_WIDTH'(STACK_DEPTH);
  localparam logic [ADDR_WIDTH-1:0] PC_ONE    = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH-1:0] PC_ALL1   = '1;

  logic [ADDR_WIDTH-1:0] pc_q;
  logic [SP_WIDTH-1:0]   level_q;
  logic [SP_WIDTH-1:0]   level_dec;
  logic [ADDR_WIDTH-1:0] stack_mem [STACK_DEPTH];
  logic [ADDR_WIDTH-1:0] stack_top;
  logic [ADDR_WIDTH-1:0] bus_in;
  logic                  ovf_q;
  logic                  unf_q;
  op_e                   op;

  // The PC is the only driver of its own bus slice; released otherwise.
  assign w_bus = enable ? pc_q : {ADDR_WIDTH{1'bz}};

  // While we drive the bus ourselves, take our own PC instead of the resolved
  // net so a simultaneous load/call never picks up an undriven value.
  assign bus_in = enable ? pc_q : w_bus;

  assign pc_out      = pc_q;
  assign stack_level = level_q;
  assign stack_full  = (level_q == SP_DEPTH);
  assign stack_empty = (level_q == '0);
  assign stack_ovf   = ovf_q;
  assign stack_unf   = unf_q;
  assign level_dec   = level_q - SP_ONE;

  // One operation per edge, strict priority ret > call > load > cp.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    op = OP_HOLD;
    if (ret)       op = stack_empty ? OP_RET_REJECT  : OP_RET;
    else if (call) op = stack_full  ? OP_CALL_REJECT : OP_CALL;
    else if (load) op = OP_LOAD;
    else if (cp)   op = OP_COUNT;
  end

  always_comb begin
    stack_top = '0;
    for (int i = 0; i < STACK_DEPTH; i++) begin
      if (SP_WIDTH'(i) == level_dec) stack_top = stack_mem[i];
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (reset) begin
      pc_q    <= '0;
      level_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      unique case (op)
        OP_COUNT:       pc_q <= pc_q + PC_ONE;
        OP_LOAD:        pc_q <= bus_in;
        OP_CALL: begin
          pc_q    <= bus_in;
          level_q <= level_q + SP_ONE;
        end
        OP_CALL_REJECT: ovf_q <= 1'b1;
        OP_RET: begin
          pc_q    <= stack_top;
          level_q <= level_dec;
        end
        OP_RET_REJECT:  unf_q <= 1'b1;
        default:        ;
      endcase
    end
  end

  // NOTE: the stack storage is reset explicitly (register array, not a RAM
  // macro) so a RET after reset can never return stale contents.
  always_ff @(posedge clk) begin
    for (int i = 0; i < STACK_DEPTH; i++) begin
      if (reset) begin
        stack_mem[i] <= '0;
      end else if (op == OP_CALL && SP_WIDTH'(i) == level_q) begin
        stack_mem[i] <= pc_q;
      end
    end
  end

`ifdef PC_WRAP_FLAG_EN
  always_ff @(posedge clk) begin
    if (reset) pc_wrap <= 1'b0;
    else       pc_wrap <= (op == OP_COUNT) && (pc_q == PC_ALL1);
  end
`endif

endmodule

// File: tb/tb_program_counter_stack.sv
// Self-checking bench: directed scenarios plus random control traffic, checked
// against a queue-based reference model of the PC and return stack.
module tb_program_counter_stack;

  localparam int AW    = 4;
  localparam int DEPTH = 4;
  localparam int SPW   = 3;
  localparam int PC_MOD = 1 << AW;

  logic           clk = 1'b0;
  logic           reset, cp, enable, load, call, ret;
  logic           drv_en;
  logic [AW-1:0]  drv_val;
  wire  [AW-1:0]  w_bus;
  logic [AW-1:0]  pc_out;
  logic [SPW-1:0] stack_level;
  logic           stack_full, stack_empty, stack_ovf, stack_unf;
`ifdef PC_WRAP_FLAG_EN
  logic           pc_wrap;
`endif

  int checks   = 0;
  int failures = 0;

  // Reference model state
  int m_pc;
  int m_stack[$];
  bit m_ovf, m_unf, m_wrap;

  assign w_bus = drv_en ? drv_val : {AW{1'bz}};

  program_counter_stack #(
    .ADDR_WIDTH (AW),
    .STACK_DEPTH(DEPTH),
    .SP_WIDTH   (SPW)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .cp         (cp),
    .enable     (enable),
    .load       (load),
    .call       (call),
    .ret        (ret),
    .w_bus      (w_bus),
    .pc_out     (pc_out),
    .stack_level(stack_level),
    .stack_full (stack_full),
    .stack_empty(stack_empty),
    .stack_ovf  (stack_ovf),
    .stack_unf  (stack_unf)
`ifdef PC_WRAP_FLAG_EN
    ,
    .pc_wrap    (pc_wrap)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic check_state(input string tag);
    check({tag, ".pc"},    32'(pc_out),      32'(m_pc));
    check({tag, ".level"}, 32'(stack_level), 32'(m_stack.size()));
    check({tag, ".full"},  32'(stack_full),  32'(m_stack.size() == DEPTH));
    check({tag, ".empty"}, 32'(stack_empty), 32'(m_stack.size() == 0));
    check({tag, ".ovf"},   32'(stack_ovf),   32'(m_ovf));
    check({tag, ".unf"},   32'(stack_unf),   32'(m_unf));
`ifdef PC_WRAP_FLAG_EN
    check({tag, ".wrap"},  32'(pc_wrap),     32'(m_wrap));
`endif
  endtask

  // One clock: drive at negedge, check bus before the edge, update model at
  // the edge, check registered state 1 time unit later.
  task automatic step(input string tag, input bit r, input bit c, input bit e,
                      input bit l, input bit ca, input bit rt, input int bus);
    int bus_val;
    @(negedge clk);
    reset = r; cp = c; enable = e; load = l; call = ca; ret = rt;
    drv_en  = !e;
    drv_val = AW'(bus);
    #1;
    bus_val = e ? m_pc : (bus % PC_MOD);
    if (!r) check({tag, ".bus"}, 32'(w_bus), 32'(bus_val));
    @(posedge clk);
    m_wrap = 1'b0;
    if (r) begin
      m_pc = 0; m_stack.delete(); m_ovf = 0; m_unf = 0;
    end else if (rt) begin
      if (m_stack.size() > 0) m_pc = m_stack.pop_back();
      else                    m_unf = 1;
    end else if (ca) begin
      if (m_stack.size() < DEPTH) begin
        m_stack.push_back(m_pc);
        m_pc = bus_val;
      end else m_ovf = 1;
    end else if (l) begin
      m_pc = bus_val;
    end else if (c) begin
      m_wrap = (m_pc == PC_MOD - 1);
      m_pc   = (m_pc + 1) % PC_MOD;
    end
    #1;
    check_state(tag);
  endtask

  initial begin
    reset = 1'b1; cp = 0; enable = 0; load = 0; call = 0; ret = 0;
    drv_en = 1'b1; drv_val = '0;
    m_pc = 0; m_ovf = 0; m_unf = 0; m_wrap = 0;

    // Reset then count with the bus driven by the PC
    step("reset", 1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) step("count", 0, 1, 1, 0, 0, 0, 0);
    step("bus_release", 0, 0, 0, 0, 0, 0, 9);

    // Wrap from all-ones back to zero
    step("reset", 1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 17; i++) step("wrap", 0, 1, 0, 0, 0, 0, 0);

    // Jump priority and rejected ret on empty stack
    step("load3", 0, 0, 0, 1, 0, 0, 3);
    step("load_vs_cp", 0, 1, 0, 1, 0, 0, 'hA);
    step("ret_empty", 0, 1, 0, 1, 1, 1, 5);

    // Self-sampled bus: load leaves PC, call pushes PC and jumps to PC
    step("load_self", 0, 0, 1, 1, 0, 0, 0);
    step("call_self", 0, 0, 1, 0, 1, 0, 0);
    step("ret_self", 0, 0, 0, 0, 0, 1, 0);

    // Call/return nesting
    step("reset", 1, 0, 0, 0, 0, 0, 0);
    step("load2", 0, 0, 0, 1, 0, 0, 2);
    step("call8", 0, 0, 0, 0, 1, 0, 8);
    step("cp9", 0, 1, 0, 0, 0, 0, 0);
    step("callC", 0, 0, 0, 0, 1, 0, 'hC);
    step("ret1", 0, 0, 0, 0, 0, 1, 0);
    step("ret2", 0, 0, 0, 0, 0, 1, 0);

    // Overflow then LIFO recovery
    for (int i = 1; i <= 5; i++) step("call_ovf", 0, 0, 0, 0, 1, 0, i);
    for (int i = 0; i < 4; i++) step("ret_lifo", 0, 0, 0, 0, 0, 1, 0);

    // Reset mid-operation with a call on the same edge
    for (int i = 1; i <= 5; i++) step("refill", 0, 0, 0, 0, 1, 0, i + 7);
    step("ret_to3", 0, 0, 0, 0, 0, 1, 0);
    step("reset_call", 1, 0, 0, 0, 1, 0, 6);

    // Random traffic
    for (int i = 0; i < 2000; i++) begin
      step("rand", ($urandom_range(0, 99) == 0), $urandom_range(0, 1) == 1,
           $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
           $urandom_range(0, 4) == 0, $urandom_range(0, 4) == 0,
           int'($urandom_range(0, PC_MOD - 1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
